// File: rtl/main_controller_pkg.sv
// rtl/main_controller_pkg.sv - shared opcodes, state codes, ALU_op codes and control word
package main_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef logic [3:0] state_t;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       branch;
    logic       pc_write;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/main_controller_outputs.sv
// rtl/main_controller_outputs.sv - Moore decode of FSM state to the datapath control word
module main_controller_outputs
  import main_controller_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_controller.sv
// rtl/main_controller.sv - multicycle control FSM: state register, next-state logic and PC_en
module main_controller
  import main_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [1:0] ALU_op,
  output logic       IorD,
  output logic       IR_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ALU_src_A,
  output logic       branch,
  output logic       PC_write,
  output logic [1:0] ALU_src_B,
  output logic [1:0] PC_src,
  output logic       PC_en
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:    state_d = S_MEMWB;
      S_EXEC:     state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  main_controller_outputs u_outputs (
    .state (state_q),
    .ctrl  (ctrl_raw)
  );

  // Reset holds the state in FETCH, whose strobes must not reach the datapath.
  assign ctrl = rst_n ? ctrl_raw : '0;

  assign ALU_op     = ctrl.alu_op;
  assign IorD       = ctrl.iord;
  assign IR_write   = ctrl.ir_write;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign ALU_src_A  = ctrl.alu_src_a;
  assign branch     = ctrl.branch;
  assign PC_write   = ctrl.pc_write;
  assign ALU_src_B  = ctrl.alu_src_b;
  assign PC_src     = ctrl.pc_src;
  assign PC_en      = ctrl.pc_write | (ctrl.branch & zero);

endmodule

// File: tb/tb_main_controller.sv
// tb/tb_main_controller.sv - directed self-checking bench for main_controller
module tb_main_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic [1:0] ALU_op;
  logic       IorD, IR_write, mem_write, reg_write, reg_dst, mem_to_reg;
  logic       ALU_src_A, branch, PC_write, PC_en;
  logic [1:0] ALU_src_B, PC_src;

  int checks   = 0;
  int failures = 0;
  logic alu_op_11_seen = 1'b0;

  main_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .ALU_op     (ALU_op),
    .IorD       (IorD),
    .IR_write   (IR_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .ALU_src_A  (ALU_src_A),
    .branch     (branch),
    .PC_write   (PC_write),
    .ALU_src_B  (ALU_src_B),
    .PC_src     (PC_src),
    .PC_en      (PC_en)
  );

  // {ALU_op, IorD, IR_write, mem_write, reg_write, reg_dst, mem_to_reg,
  //  ALU_src_A, branch, PC_write, ALU_src_B, PC_src, PC_en}
  logic [15:0] obs;
  assign obs = {ALU_op, IorD, IR_write, mem_write, reg_write, reg_dst, mem_to_reg,
                ALU_src_A, branch, PC_write, ALU_src_B, PC_src, PC_en};

  localparam logic [15:0] W_FETCH  = 16'h1029;
  localparam logic [15:0] W_DECODE = 16'h0018;
  localparam logic [15:0] W_ADR    = 16'h0090;
  localparam logic [15:0] W_MEMRD  = 16'h2000;
  localparam logic [15:0] W_MEMWB  = 16'h0500;
  localparam logic [15:0] W_MEMWR  = 16'h2800;
  localparam logic [15:0] W_EXEC   = 16'h8080;
  localparam logic [15:0] W_ALUWB  = 16'h0600;
  localparam logic [15:0] W_BR_T   = 16'h40C3;
  localparam logic [15:0] W_BR_N   = 16'h40C2;
  localparam logic [15:0] W_ADDIWB = 16'h0400;
  localparam logic [15:0] W_JUMP   = 16'h0025;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ALU_op == 2'b11) alu_op_11_seen <= 1'b1;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts sampled in FETCH; checks n cycles then steps into the next FETCH.
  task automatic run_instr(input string name, input logic [5:0] op_v, input logic z,
                           input logic [15:0] w [6], input int n);
    op   = op_v;
    zero = z;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      check($sformatf("%s_c%0d", name, i + 1), obs, w[i]);
    end
    step();
  endtask

  initial begin
    logic [15:0] w [6];
    rst_n = 1'b0;
    op    = 6'b000000;
    zero  = 1'b0;
    #12;
    check("reset_low_outputs", obs, 16'h0000);
    zero = 1'b1;
    #1;
    check("reset_low_pc_en", obs, 16'h0000);
    zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    w = '{W_FETCH, W_DECODE, W_ADR, W_MEMRD, W_MEMWB, 16'h0};
    run_instr("lw", 6'b100011, 1'b0, w, 5);
    w = '{W_FETCH, W_DECODE, W_EXEC, W_ALUWB, 16'h0, 16'h0};
    run_instr("rtype", 6'b000000, 1'b0, w, 4);
    w = '{W_FETCH, W_DECODE, W_ADR, W_ADDIWB, 16'h0, 16'h0};
    run_instr("addi", 6'b001000, 1'b0, w, 4);
    w = '{W_FETCH, W_DECODE, W_BR_T, 16'h0, 16'h0, 16'h0};
    run_instr("beq_taken", 6'b000100, 1'b1, w, 3);
    w = '{W_FETCH, W_DECODE, W_BR_N, 16'h0, 16'h0, 16'h0};
    run_instr("beq_not", 6'b000100, 1'b0, w, 3);
    w = '{W_FETCH, W_DECODE, 16'h0, 16'h0, 16'h0, 16'h0};
    run_instr("illegal", 6'b111111, 1'b0, w, 2);
    w = '{W_FETCH, W_DECODE, W_JUMP, 16'h0, 16'h0, 16'h0};
    run_instr("jump", 6'b000010, 1'b0, w, 3);
    w = '{W_FETCH, W_DECODE, W_ADR, W_MEMWR, 16'h0, 16'h0};
    run_instr("sw", 6'b101011, 1'b0, w, 4);

    // SW again, aborted by reset in MEMWR
    op = 6'b101011;
    check("sw_abort_fetch", obs, W_FETCH);
    step();
    step();
    step();
    check("sw_abort_memwr", obs, W_MEMWR);
    #1;
    rst_n = 1'b0;
    #1;
    check("sw_abort_async_zero", obs, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sw_abort_release_fetch", obs, W_FETCH);
    step();
    check("sw_abort_then_decode", obs, W_DECODE);
    step();
    step();
    step();
    w = '{W_FETCH, W_DECODE, W_JUMP, 16'h0, 16'h0, 16'h0};
    run_instr("jump2", 6'b000010, 1'b0, w, 3);

    check("alu_op_never_11", {15'd0, alu_op_11_seen}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
